bulls_cows_n: RTL and testbench

- Parametrised N-player, N-digit Bulls & Cows game controller. It is the next generation of the fixed 2-player/4-hex-digit game FSM.
- Adds the following over the fixed version:
  - configurable digit count, digit base and player count;
  - validation of both secrets and guesses, with a reject pulse;
  - per-round attempt counting;
  - saturating per-player score.
- Outputs are raw status only: state code, player, bulls, cows and scores. Seven-segment/display encoding lives in a separate downstream block.

---
 rtl/bulls_cows_n.sv | 212 +++++++++++++++++++++
 tb/tb_bulls_cows_n.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bulls_cows_n.sv
// bulls_cows_n: parametrised N-player, N-digit Bulls & Cows game controller.
// Each player sets a secret and then guesses the secret of the next player.
// Secrets and guesses are checked for range and distinct digits, and an
// invalid one gives a one-cycle reject pulse. The block counts the accepted
// guesses in each round and keeps a saturating win score for each player.
// The outputs are raw status only. Display encoding is done downstream.
//
// Optional feature: define BC_ATTEMPT_LIMIT_EN to end a round in DRAW when
// the accepted-guess count reaches MAX_ATTEMPTS without a winner.
//
// state | meaning
// ------+-----------------------------------------------------------
// 0     | SECRET: player enters a secret; the last player moves to GUESS
// 1     | GUESS : player guesses the secret of player (player+1)%N
// 2     | RESULT: bulls/cows shown; tick passes the turn to the next player
// 3     | WIN   : player is the winner; tick starts a new round
// 4     | DRAW  : attempt limit reached; tick starts a new round
module bulls_cows_n #(
   parameter int NUM_DIGITS   = 4,
   parameter int DIGIT_W      = 4,
   parameter int BASE         = 10,
   parameter int NUM_PLAYERS  = 2,
   parameter int SCORE_W      = 8,
   parameter int ATT_W        = 8,
   parameter int MAX_ATTEMPTS = 20,
   localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
   localparam int CW = $clog2(NUM_DIGITS + 1),
   localparam int GW = NUM_DIGITS * DIGIT_W
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [GW-1:0]                  guess,
   input  logic                           confirm,
   output logic [2:0]                     state,
   output logic [PW-1:0]                  player,
   output logic [CW-1:0]                  bulls,
   output logic [CW-1:0]                  cows,
   output logic                           reject,
   output logic [ATT_W-1:0]               attempts,
   output logic [NUM_PLAYERS*SCORE_W-1:0] scores
);

   typedef enum logic [2:0] {
      S_SECRET = 3'd0,
      S_GUESS  = 3'd1,
      S_RESULT = 3'd2,
      S_WIN    = 3'd3,
      S_DRAW   = 3'd4
   } state_t;

   state_t                           state_q, state_d;
   logic [PW-1:0]                    player_q, player_d;
   logic [CW-1:0]                    bulls_q, bulls_d;
   logic [CW-1:0]                    cows_q, cows_d;
   logic                             reject_q, reject_d;
   logic [ATT_W-1:0]                 attempts_q, attempts_d;
   logic [NUM_PLAYERS*SCORE_W-1:0]   scores_q, scores_d;
   logic [GW-1:0]                    secret_q [NUM_PLAYERS];
   logic [GW-1:0]                    secret_d [NUM_PLAYERS];
   logic                             confirm_q;

   logic             tick;
   logic             guess_ok;
   logic [PW-1:0]    next_player;
   logic [GW-1:0]    target;
   logic [CW-1:0]    bulls_calc;
   logic [CW-1:0]    cows_calc;
   logic [ATT_W-1:0] att_inc;

   function automatic logic [DIGIT_W-1:0] digit(input logic [GW-1:0] v, input int i);
      return v[i*DIGIT_W +: DIGIT_W];
   endfunction

   assign tick = confirm & ~confirm_q;

   // Turn rotation. The same wrap is used to select the guess target and to pass the turn on.
   assign next_player = (player_q == PW'(NUM_PLAYERS - 1)) ? '0 : player_q + PW'(1);
   assign target      = secret_q[next_player];
   assign att_inc     = (attempts_q == '1) ? attempts_q : attempts_q + ATT_W'(1);

   // Validity check: every digit is in range and all digits are pairwise distinct.
   always_comb begin
      guess_ok = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (32'(digit(guess, i)) >= BASE) guess_ok = 1'b0;
         for (int j = i + 1; j < NUM_DIGITS; j++) begin
            if (digit(guess, i) == digit(guess, j)) guess_ok = 1'b0;
         end
      end
   end

   // Score the guess against the target. The sum never exceeds NUM_DIGITS, so CW bits are enough.
   always_comb begin
      logic hit;
      bulls_calc = '0;
      cows_calc  = '0;
      hit        = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit(guess, i) == digit(target, i)) bulls_calc = bulls_calc + CW'(1);
         hit = 1'b0;
         for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j != i && digit(guess, i) == digit(target, j)) hit = 1'b1;
         end
         if (hit) cows_calc = cows_calc + CW'(1);
      end
   end

   // Next-state and output decode. Every action happens only on a confirm tick.
   always_comb begin
      state_d    = state_q;
      player_d   = player_q;
      bulls_d    = bulls_q;
      cows_d     = cows_q;
      reject_d   = 1'b0;
      attempts_d = attempts_q;
      scores_d   = scores_q;
      for (int p = 0; p < NUM_PLAYERS; p++) secret_d[p] = secret_q[p];

      if (tick) begin
         unique case (state_q)
            S_SECRET: begin
               if (!guess_ok) begin
                  reject_d = 1'b1;
               end else begin
                  for (int p = 0; p < NUM_PLAYERS; p++) begin
                     if (PW'(p) == player_q) secret_d[p] = guess;
                  end
                  player_d = next_player;
                  if (player_q == PW'(NUM_PLAYERS - 1)) state_d = S_GUESS;
               end
            end
            S_GUESS: begin
               if (!guess_ok) begin
                  reject_d = 1'b1;
               end else begin
                  bulls_d    = bulls_calc;
                  cows_d     = cows_calc;
                  attempts_d = att_inc;
                  if (bulls_calc == CW'(NUM_DIGITS)) begin
                     state_d = S_WIN;
                     for (int p = 0; p < NUM_PLAYERS; p++) begin
                        if (PW'(p) == player_q &&
                            scores_q[p*SCORE_W +: SCORE_W] != '1) begin
                           scores_d[p*SCORE_W +: SCORE_W] =
                              scores_q[p*SCORE_W +: SCORE_W] + SCORE_W'(1);
                        end
                     end
`ifdef BC_ATTEMPT_LIMIT_EN
                  end else if (att_inc == ATT_W'(MAX_ATTEMPTS)) begin
                     state_d = S_DRAW;
`endif
                  end else begin
                     state_d = S_RESULT;
                  end
               end
            end
            S_RESULT: begin
               player_d = next_player;
               state_d  = S_GUESS;
            end
            S_WIN, S_DRAW: begin
               state_d    = S_SECRET;
               player_d   = '0;
               attempts_d = '0;
               bulls_d    = '0;
               cows_d     = '0;
            end
            default: state_d = S_SECRET;
         endcase
      end
   end

`ifndef BC_ATTEMPT_LIMIT_EN
   // Without the attempt limit the round length is unbounded and MAX_ATTEMPTS has no effect.
   logic unused_max_attempts;
   assign unused_max_attempts = (MAX_ATTEMPTS > 0);
`endif

   // State register. Asserting reset clears the whole game, including the scores.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_SECRET;
         player_q   <= '0;
         bulls_q    <= '0;
         cows_q     <= '0;
         reject_q   <= 1'b0;
         attempts_q <= '0;
         scores_q   <= '0;
         confirm_q  <= 1'b0;
         for (int p = 0; p < NUM_PLAYERS; p++) secret_q[p] <= '0;
      end else begin
         state_q    <= state_d;
         player_q   <= player_d;
         bulls_q    <= bulls_d;
         cows_q     <= cows_d;
         reject_q   <= reject_d;
         attempts_q <= attempts_d;
         scores_q   <= scores_d;
         confirm_q  <= confirm;
         for (int p = 0; p < NUM_PLAYERS; p++) secret_q[p] <= secret_d[p];
      end
   end

   assign state    = state_q;
   assign player   = player_q;
   assign bulls    = bulls_q;
   assign cows     = cows_q;
   assign reject   = reject_q;
   assign attempts = attempts_q;
   assign scores   = scores_q;

endmodule

// File: tb/tb_bulls_cows_n.sv
// Directed bench for bulls_cows_n: 2 players, 4 decimal digits, MAX_ATTEMPTS=3.
module tb_bulls_cows_n;

`ifdef BC_ATTEMPT_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   logic        clock;
   logic        reset_n;
   logic [15:0] guess;
   logic        confirm;
   logic [2:0]  state;
   logic [0:0]  player;
   logic [2:0]  bulls;
   logic [2:0]  cows;
   logic        reject;
   logic [7:0]  attempts;
   logic [15:0] scores;

   int errors = 0;
   int checks = 0;

   bulls_cows_n #(
      .NUM_DIGITS(4), .DIGIT_W(4), .BASE(10), .NUM_PLAYERS(2),
      .SCORE_W(8), .ATT_W(8), .MAX_ATTEMPTS(3)
   ) dut (
      .clock(clock), .reset_n(reset_n), .guess(guess), .confirm(confirm),
      .state(state), .player(player), .bulls(bulls), .cows(cows),
      .reject(reject), .attempts(attempts), .scores(scores)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] g;
      logic [2:0]  st;
      logic [0:0]  pl;
      logic [2:0]  b;
      logic [2:0]  c;
      logic        rej;
      logic [7:0]  att;
      logic [15:0] sc;
   } vec_t;

   vec_t vecs [23];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] st, input logic [0:0] pl,
                          input logic [2:0] b, input logic [2:0] c, input logic rej,
                          input logic [7:0] att, input logic [15:0] sc);
      chk({tag, ".state"},    32'(state),    32'(st));
      chk({tag, ".player"},   32'(player),   32'(pl));
      chk({tag, ".bulls"},    32'(bulls),    32'(b));
      chk({tag, ".cows"},     32'(cows),     32'(c));
      chk({tag, ".reject"},   32'(reject),   32'(rej));
      chk({tag, ".attempts"}, 32'(attempts), 32'(att));
      chk({tag, ".scores"},   32'(scores),   32'(sc));
   endtask

   // One tick: drive the guess, raise confirm, sample just after the edge.
   task automatic press(input logic [15:0] g);
      guess   = g;
      confirm = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic release_btn();
      confirm = 1'b0;
      @(posedge clock);
      #1;
   endtask

   function automatic vec_t mk(input logic [15:0] g, input logic [2:0] st, input logic [0:0] pl,
                               input logic [2:0] b, input logic [2:0] c, input logic rej,
                               input logic [7:0] att, input logic [15:0] sc);
      vec_t v;
      v.g = g; v.st = st; v.pl = pl; v.b = b; v.c = c; v.rej = rej; v.att = att; v.sc = sc;
      return v;
   endfunction

   initial begin
      // Secrets enter in SECRET. Rejects happen only in SECRET or GUESS.
      vecs[0]  = mk(16'h1123, 0, 0, 0, 0, 1, 0, 16'h0000);
      vecs[1]  = mk(16'h12A4, 0, 0, 0, 0, 1, 0, 16'h0000);
      vecs[2]  = mk(16'h9876, 0, 1, 0, 0, 0, 0, 16'h0000);
      vecs[3]  = mk(16'h5678, 1, 0, 0, 0, 0, 0, 16'h0000);
      vecs[4]  = mk(16'h5687, 2, 0, 2, 2, 0, 1, 16'h0000);
      vecs[5]  = mk(16'h1111, 1, 1, 2, 2, 0, 1, 16'h0000);
      vecs[6]  = mk(16'h9876, 3, 1, 4, 0, 0, 2, 16'h0100);
      vecs[7]  = mk(16'h0000, 0, 0, 0, 0, 0, 0, 16'h0100);
      vecs[8]  = mk(16'h1234, 0, 1, 0, 0, 0, 0, 16'h0100);
      vecs[9]  = mk(16'h5678, 1, 0, 0, 0, 0, 0, 16'h0100);
      vecs[10] = mk(16'h1232, 1, 0, 0, 0, 1, 0, 16'h0100);
      vecs[11] = mk(16'h5687, 2, 0, 2, 2, 0, 1, 16'h0100);
      vecs[12] = mk(16'hAAAA, 1, 1, 2, 2, 0, 1, 16'h0100);
      vecs[13] = mk(16'h1234, 3, 1, 4, 0, 0, 2, 16'h0200);
      vecs[14] = mk(16'h0000, 0, 0, 0, 0, 0, 0, 16'h0200);
      vecs[15] = mk(16'h1234, 0, 1, 0, 0, 0, 0, 16'h0200);
      vecs[16] = mk(16'h5678, 1, 0, 0, 0, 0, 0, 16'h0200);
      vecs[17] = mk(16'h0123, 2, 0, 0, 0, 0, 1, 16'h0200);
      vecs[18] = mk(16'h0000, 1, 1, 0, 0, 0, 1, 16'h0200);
      vecs[19] = mk(16'h4321, 2, 1, 0, 4, 0, 2, 16'h0200);
      vecs[20] = mk(16'h0000, 1, 0, 0, 4, 0, 2, 16'h0200);
      vecs[21] = mk(16'h5679, LIM ? 3'd4 : 3'd2, 0, 3, 0, 0, 3, 16'h0200);
      vecs[22] = LIM ? mk(16'h0000, 0, 0, 0, 0, 0, 0, 16'h0200)
                     : mk(16'h0000, 1, 1, 3, 0, 0, 3, 16'h0200);

      reset_n = 1'b0;
      confirm = 1'b0;
      guess   = '0;
      #12;
      chk_all("reset", 0, 0, 0, 0, 0, 0, 16'h0000);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk_all("idle", 0, 0, 0, 0, 0, 0, 16'h0000);

      for (int k = 0; k < 23; k++) begin
         press(vecs[k].g);
         chk_all($sformatf("vec%0d", k), vecs[k].st, vecs[k].pl, vecs[k].b, vecs[k].c,
                 vecs[k].rej, vecs[k].att, vecs[k].sc);
         release_btn();
         chk($sformatf("vec%0d.reject_low", k), 32'(reject), 32'd0);
      end

      // Return to GUESS. After a DRAW this needs a fresh pair of secrets.
      if (LIM) begin
         press(16'h1234); release_btn();
         press(16'h5678); release_btn();
         chk("limit.reguess", 32'(state), 32'd1);
      end

      // Confirm held for 10 cycles must count as a single guess.
      guess   = 16'h0123;
      confirm = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      chk("hold.state",    32'(state),    32'd2);
      chk("hold.attempts", 32'(attempts), LIM ? 32'd1 : 32'd4);
      chk("hold.cows",     32'(cows),     LIM ? 32'd0 : 32'd3);
      release_btn();
      press(16'h0000);
      release_btn();
      chk("hold.back_guess", 32'(state), 32'd1);

      // Asynchronous reset mid-GUESS clears everything, including the scores.
      #3;
      reset_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 0, 0, 16'h0000);

      // Confirm held high through reset release gives exactly one tick.
      guess   = 16'h1234;
      confirm = 1'b1;
      @(posedge clock);
      #3;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("rel_tick.player", 32'(player), 32'd1);
      repeat (5) @(posedge clock);
      #1;
      chk("rel_hold.player", 32'(player), 32'd1);
      chk("rel_hold.state",  32'(state),  32'd0);
      confirm = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
